// File: rtl/serial_ripple_subtractor_if.sv
// Bus for serial_ripple_subtractor.
//   master : drives start/i0/i1; observes busy/done/o/bout/state_dbg
//   slave  : the subtractor itself
// Handshake: start is sampled only while the engine is idle (busy=0 and
// done=0). The edge that samples it also captures i0/i1. done is a single-cycle
// pulse that marks o/bout as freshly updated. o/bout hold their value until the
// next completion or until reset.
interface serial_ripple_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   o;
  logic             bout;
  logic [1:0]       state_dbg;

  modport master (
    output start, i0, i1,
    input  busy, done, o, bout, state_dbg
  );

  modport slave (
    input  start, i0, i1,
    output busy, done, o, bout, state_dbg
  );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor. It computes o = {bout, i0 - i1} one bit per clock,
// starting at the LSB.
// Ports:
//   clk   : single clock; all state changes on its rising edge
//   reset : synchronous, active-high; has priority over start
//   bus   : serial_ripple_subtractor_if slave modport
//           start/i0/i1 in; busy/done/o/bout/state_dbg out
// Timing: if start is accepted at edge N, the engine runs WIDTH RUN edges.
// Edge N+WIDTH loads o/bout and enters DONE, so done is high for the cycle
// that follows edge N+WIDTH.
module serial_ripple_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                     clk,
  input logic                     reset,
  serial_ripple_subtractor_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             brw_reg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   o_reg;
  logic             bout_reg;

  logic             last_bit;
  logic             ak;
  logic             bk;
  logic             d_bit;
  logic             brw_next;
  logic [WIDTH-1:0] diff_upd;

  // Full-subtractor cell applied to bit cnt of the latched operands.
  always_comb begin
    ak       = a_reg[cnt];
    bk       = b_reg[cnt];
    d_bit    = ak ^ bk ^ brw_reg;
    brw_next = (~ak & bk) | (~(ak ^ bk) & brw_reg);
    diff_upd = diff_reg;
    diff_upd[cnt] = d_bit;
    last_bit = (cnt == CNT_W'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath. The counter returns to 0 on the last bit instead of
  // incrementing, so it never wraps even when WIDTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      diff_reg <= '0;
      brw_reg  <= 1'b0;
      cnt      <= '0;
      o_reg    <= '0;
      bout_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg    <= bus.i0;
            b_reg    <= bus.i1;
            diff_reg <= '0;
            brw_reg  <= 1'b0;
            cnt      <= '0;
          end
        end
        RUN: begin
          diff_reg <= diff_upd;
          brw_reg  <= brw_next;
          if (last_bit) begin
            cnt      <= '0;
            o_reg    <= {brw_next, diff_upd};
            bout_reg <= brw_next;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.o         = o_reg;
  assign bus.bout      = bout_reg;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
module tb_serial_ripple_subtractor;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  int   cyc;
  logic rst_at_edge;
  bit   mon_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         = cyc + 1;
    rst_at_edge = reset;
  end

  serial_ripple_subtractor_if #(.WIDTH(W)) bus ();

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];     // expected o; bit W is also the expected bout
  int         exp_cyc_q[$]; // cycle count at which done must be seen
  int         total;
  int         bad;
  logic [W:0] prev_o;
  logic       prev_bout;
  logic       exp_busy;

  // Reference: unsigned difference taken modulo 2^(W+1); borrow when i0 < i1.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned full;
    full = (int'(a) - int'(b) + (1 << (W + 1))) % (1 << (W + 1));
    return full[W:0];
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en && !rst_at_edge) begin
      exp_busy = (exp_cyc_q.size() > 0) && (cyc < exp_cyc_q[0]);
      total++;
      if (bus.busy !== exp_busy) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_busy);
      end
      if (exp_cyc_q.size() > 0 && cyc == exp_cyc_q[0]) begin
        total++;
        if (bus.done !== 1'b1) begin
          bad++;
          $display("FAIL done_missing cyc=%0d got=%b exp=1", cyc, bus.done);
        end else begin
          total += 2;
          if (bus.o !== exp_q[0]) begin
            bad++;
            $display("FAIL o cyc=%0d got=%h exp=%h", cyc, bus.o, exp_q[0]);
          end
          if (bus.bout !== exp_q[0][W]) begin
            bad++;
            $display("FAIL bout cyc=%0d got=%b exp=%b", cyc, bus.bout, exp_q[0][W]);
          end
        end
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end else begin
        total++;
        if (bus.done !== 1'b0) begin
          bad++;
          $display("FAIL done_unexpected cyc=%0d got=%b exp=0", cyc, bus.done);
        end
        total++;
        if (bus.o !== prev_o || bus.bout !== prev_bout) begin
          bad++;
          $display("FAIL o_stable cyc=%0d got=%h/%b exp=%h/%b", cyc, bus.o, bus.bout, prev_o, prev_bout);
        end
      end
    end
    prev_o    = bus.o;
    prev_bout = bus.bout;
  end

  // ---------------- driver ----------------
  // Called at a negedge. Returns at the negedge after acceptance, or, with
  // hold=1, at the negedge where done is observed.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    int guard;
    guard = 0;
    while ((bus.busy || bus.done) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      total++;
      bad++;
      $display("FAIL idle_timeout cyc=%0d got=busy exp=idle", cyc);
    end
    bus.i0    = a;
    bus.i1    = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(ref_sub(a, b));
    exp_cyc_q.push_back(cyc + W);
    @(negedge clk);
    if (hold) begin
      guard = 0;
      while (!bus.done && guard < 4 * W) begin
        bus.i0 = W'($urandom);
        bus.i1 = W'($urandom);
        @(negedge clk);
        guard++;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      total++;
      bad++;
      $display("FAIL drain_timeout cyc=%0d got=%0d exp=0 pending", cyc, exp_q.size());
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cyc         = 0;
    total       = 0;
    bad         = 0;
    mon_en      = 1'b0;
    rst_at_edge = 1'b1;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.i0      = '0;
    bus.i1      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset values
    total += 4;
    if (bus.o !== '0)      begin bad++; $display("FAIL rst_o got=%h exp=0", bus.o); end
    if (bus.bout !== 1'b0) begin bad++; $display("FAIL rst_bout got=%b exp=0", bus.bout); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.done); end
    mon_en = 1'b1;

    // Start accepted on the first non-reset idle cycle
    issue(8'h01, 8'h00, 1'b0);
    drain();

    // Back-to-back pairs
    issue(8'h01, 8'h01, 1'b0);
    issue(8'hFF, 8'h01, 1'b0);
    issue(8'hCC, 8'hBB, 1'b0);
    drain();

    // Negative results
    issue(8'hAF, 8'hFA, 1'b0);
    issue(8'h00, 8'hFF, 1'b0);
    drain();

    // start held high while operands change during RUN
    issue(8'h5A, 8'h3C, 1'b1);
    drain();

    // Reset during the 4th RUN cycle aborts the operation
    issue(8'h77, 8'h22, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    reset = 1'b0;
    total += 4;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", bus.done); end
    if (bus.o !== '0)      begin bad++; $display("FAIL abort_o got=%h exp=0", bus.o); end
    if (bus.bout !== 1'b0) begin bad++; $display("FAIL abort_bout got=%b exp=0", bus.bout); end
    repeat (2 * W) @(negedge clk);  // any done here is flagged by the monitor
    issue(8'h10, 8'h20, 1'b0);
    drain();

    // Random operands, mixing back-to-back and spaced issues
    for (int i = 0; i < 60; i++) begin
      issue(W'($urandom), W'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    // Boundary operands
    issue(8'hFF, 8'h00, 1'b0);
    issue(8'h00, 8'h00, 1'b0);
    issue(8'h7F, 8'h80, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net
  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
